// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared state encodings and channel constants for the mux scan sequencer
package mux_scan_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - control, mux and frame signals between the sequencer and its environment
interface mux_scan_sequencer_if;
    import mux_scan_sequencer_pkg::*;

    logic             start;
    logic             continuous;
    logic             abort;
    logic             mux_y;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  frame;
    logic             frame_valid;
    logic             busy;

    modport master (
        input  start, continuous, abort, mux_y,
        output sel, frame, frame_valid, busy
    );

    modport slave (
        output start, continuous, abort, mux_y,
        input  sel, frame, frame_valid, busy
    );
endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// rtl/mux_scan_sequencer_dwell_counter.sv - per-channel dwell counter, flags the final dwell cycle
module mux_scan_sequencer_dwell_counter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(DWELL - 1);

    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("DWELL must be in 1..255");
    end
    if ((64'd1 << CNT_W) < 64'(DWELL)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DWELL");
    end

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == LAST_V);

    // Wraps on the last dwell cycle so the count never passes DWELL-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux select through all channels and assembles the samples into frames
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.master  bus
);
    state_t          state;
    logic            cont_q;
    logic [N_CH-2:0] shadow;
    logic            last;

    mux_scan_sequencer_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == ST_IDLE) || bus.abort),
        .en   (state == ST_SCAN),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            cont_q          <= 1'b0;
            shadow          <= '0;
            bus.sel         <= '0;
            bus.frame       <= '0;
            bus.frame_valid <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state    <= ST_SCAN;
                        bus.sel  <= '0;
                        cont_q   <= bus.continuous;
                        bus.busy <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Abort outranks a frame completing on the same edge
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.sel  <= '0;
                        bus.busy <= 1'b0;
                    end else if (last) begin
                        if (bus.sel != SEL_W'(N_CH - 1)) begin
                            for (int k = 0; k < N_CH - 1; k++) begin
                                if (bus.sel == SEL_W'(k)) shadow[k] <= bus.mux_y;
                            end
                            bus.sel <= bus.sel + 1'b1;
                        end else begin
                            bus.frame       <= {bus.mux_y, shadow};
                            bus.frame_valid <= 1'b1;
                            bus.sel         <= '0;
                            if (!cont_q) begin
                                state    <= ST_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench driving three sequencers (DWELL 1,2,3) through gate-level muxes
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a [3];
    logic       cont_a  [3];
    logic       abort_a [3];
    logic [3:0] din     [3];

    wire  [1:0] sel_a   [3];
    wire  [3:0] frame_a [3];
    wire        fv_a    [3];
    wire        busy_a  [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_unit
        mux_scan_sequencer_if bus();

        mux_scan_sequencer #(.DWELL(g + 1), .CNT_W(8)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start      = start_a[g];
        assign bus.continuous = cont_a[g];
        assign bus.abort      = abort_a[g];
        assign bus.mux_y = (din[g][0] & ~bus.sel[1] & ~bus.sel[0]) |
                           (din[g][1] & ~bus.sel[1] &  bus.sel[0]) |
                           (din[g][2] &  bus.sel[1] & ~bus.sel[0]) |
                           (din[g][3] &  bus.sel[1] &  bus.sel[0]);

        assign sel_a[g]   = bus.sel;
        assign frame_a[g] = bus.frame;
        assign fv_a[g]    = bus.frame_valid;
        assign busy_a[g]  = bus.busy;
    end

    typedef struct {
        int         unit;
        logic [3:0] data;
        bit         cont;
        int         nfr;
        logic [3:0] exp_frame;
        int         exp_period;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int u, input logic [3:0] exp_frame, input string tag);
        check($sformatf("%s u%0d busy", tag, u), busy_a[u], 0);
        check($sformatf("%s u%0d sel", tag, u), sel_a[u], 0);
        check($sformatf("%s u%0d fv", tag, u), fv_a[u], 0);
        check($sformatf("%s u%0d frame", tag, u), frame_a[u], exp_frame);
    endtask

    // Reference: after edge E_j of a scan, sel = (j mod P)/D and a frame is shown exactly when j is a nonzero multiple of P
    task automatic scan_run(input int u, input logic [3:0] d, input bit cont, input int nfr,
                            input logic [3:0] exp_frame, input int period, input string tag);
        int dw;
        dw = period / 4;
        din[u]     = d;
        cont_a[u]  = cont;
        start_a[u] = 1'b1;
        tick();
        cont_a[u] = 1'b0;
        for (int j = 0; j < nfr * period; j++) begin
            start_a[u] = 1'($urandom_range(0, 1));
            cont_a[u]  = 1'($urandom_range(0, 1));
            check($sformatf("%s sel j%0d", tag, j), sel_a[u], (j % period) / dw);
            check($sformatf("%s fv j%0d", tag, j), fv_a[u], (j > 0 && j % period == 0));
            check($sformatf("%s busy j%0d", tag, j), busy_a[u], 1);
            if (j > 0 && j % period == 0)
                check($sformatf("%s frame j%0d", tag, j), frame_a[u], exp_frame);
            tick();
        end
        start_a[u] = 1'b0;
        cont_a[u]  = 1'b0;
        check($sformatf("%s final fv", tag), fv_a[u], 1);
        check($sformatf("%s final frame", tag), frame_a[u], exp_frame);
        check($sformatf("%s final sel", tag), sel_a[u], 0);
        check($sformatf("%s final busy", tag), busy_a[u], cont);
        if (cont) begin
            abort_a[u] = 1'b1;
            tick();
            abort_a[u] = 1'b0;
            check_idle(u, exp_frame, {tag, " abort"});
        end
        tick();
        check_idle(u, exp_frame, {tag, " settle"});
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            cont_a[i]  = 1'b0;
            abort_a[i] = 1'b0;
            din[i]     = 4'b0000;
        end

        tbl[0] = '{1, 4'b1101, 1'b0, 1, 4'b1101,  8};
        tbl[1] = '{0, 4'b0110, 1'b1, 3, 4'b0110,  4};
        tbl[2] = '{2, 4'b1010, 1'b0, 1, 4'b1010, 12};
        tbl[3] = '{1, 4'b0000, 1'b1, 2, 4'b0000,  8};
        tbl[4] = '{0, 4'b1111, 1'b0, 1, 4'b1111,  4};

        tick();
        tick();
        for (int u = 0; u < 3; u++) check_idle(u, 4'b0000, "reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            scan_run(tbl[i].unit, tbl[i].data, tbl[i].cont, tbl[i].nfr,
                     tbl[i].exp_frame, tbl[i].exp_period, $sformatf("tbl%0d", i));

        // Continuous at DWELL=1, then i2 drops to 0 between frames
        din[0] = 4'b0110; cont_a[0] = 1'b1; start_a[0] = 1'b1;
        tick();
        start_a[0] = 1'b0; cont_a[0] = 1'b0;
        repeat (4) tick();
        check("midstream fv1", fv_a[0], 1);
        check("midstream frame1", frame_a[0], 4'b0110);
        din[0][2] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("midstream gap%0d fv", j), fv_a[0], 0);
        end
        tick();
        check("midstream fv2", fv_a[0], 1);
        check("midstream frame2", frame_a[0], 4'b0010);
        abort_a[0] = 1'b1;
        tick();
        abort_a[0] = 1'b0;
        check_idle(0, 4'b0010, "midstream abort");

        // Abort while sel=2 at DWELL=3; previous frame 1010 must survive
        din[2] = 4'b0101; start_a[2] = 1'b1;
        tick();
        start_a[2] = 1'b0;
        repeat (7) tick();
        check("abort_sel2 sel", sel_a[2], 2);
        abort_a[2] = 1'b1;
        tick();
        abort_a[2] = 1'b0;
        check_idle(2, 4'b1010, "abort_sel2");
        tick();
        check_idle(2, 4'b1010, "abort_sel2 hold");

        // Abort on the exact completion edge
        start_a[2] = 1'b1;
        tick();
        start_a[2] = 1'b0;
        repeat (11) tick();
        check("abort_done sel", sel_a[2], 3);
        check("abort_done busy", busy_a[2], 1);
        abort_a[2] = 1'b1;
        tick();
        abort_a[2] = 1'b0;
        check_idle(2, 4'b1010, "abort_done");

        // start together with abort in IDLE stays idle
        start_a[2] = 1'b1; abort_a[2] = 1'b1;
        tick();
        start_a[2] = 1'b0; abort_a[2] = 1'b0;
        check_idle(2, 4'b1010, "start_abort");
        tick();
        check_idle(2, 4'b1010, "start_abort hold");

        for (int r = 0; r < 12; r++) begin
            int         u;
            logic [3:0] d;
            bit         c;
            int         nf;
            u  = $urandom_range(0, 2);
            d  = 4'($urandom);
            c  = 1'($urandom_range(0, 1));
            nf = c ? $urandom_range(1, 3) : 1;
            scan_run(u, d, c, nf, d, 4 * (u + 1), $sformatf("rnd%0d", r));
        end

        // Asynchronous reset mid-scan, checked before any further clock edge
        din[2] = 4'b0111; start_a[2] = 1'b1;
        tick();
        start_a[2] = 1'b0;
        repeat (5) tick();
        check("pre_rst busy", busy_a[2], 1);
        #2;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) check_idle(u, 4'b0000, "async_rst");
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
